// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver: one digit per refresh slot,
// frame-aligned value update, leading-zero blanking and enable gating.
module seg7_scan_driver #(
  parameter int unsigned NDIGITS        = 4,
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned AN_ACTIVE_LOW  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 load,
  input  logic [4*NDIGITS-1:0] value,
  input  logic [NDIGITS-1:0]   dp_in,
  input  logic                 blank_lz,
  output logic [6:0]           seg,
  output logic                 dp,
  output logic [NDIGITS-1:0]   an,
  output logic                 frame_done
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int unsigned VAL_W = 4 * NDIGITS;

  // XOR masks: applying one to an active-high pattern yields the pin polarity
  localparam logic [NDIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? {NDIGITS{1'b1}} : '0;
  localparam logic [6:0]         SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic               DP_OFF  = (SEG_ACTIVE_LOW != 0);

  logic [CNT_W-1:0]   count_q, count_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [VAL_W-1:0]   pend_v_q, pend_v_d, disp_v_q, disp_v_d;
  logic [NDIGITS-1:0] pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic [NDIGITS-1:0] an_q, an_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;
  logic               frame_done_q, frame_done_d;

  logic               tick_c, wrap_c, blank_c;
  logic [VAL_W-1:0]   upper_c;
  logic [3:0]         nib_c;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b0111111;
      4'h1: glyph = 7'b0000110;
      4'h2: glyph = 7'b1011011;
      4'h3: glyph = 7'b1001111;
      4'h4: glyph = 7'b1100110;
      4'h5: glyph = 7'b1101101;
      4'h6: glyph = 7'b1111101;
      4'h7: glyph = 7'b0000111;
      4'h8: glyph = 7'b1111111;
      4'h9: glyph = 7'b1101111;
      4'hA: glyph = 7'b1110111;
      4'hB: glyph = 7'b1111100;
      4'hC: glyph = 7'b0111001;
      4'hD: glyph = 7'b1011110;
      4'hE: glyph = 7'b1111001;
      default: glyph = 7'b1110001;
    endcase
  endfunction

  // Next-state: refresh counter, scan index, pending/display update, output images
  always_comb begin
    count_d      = count_q;
    idx_d        = idx_q;
    pend_v_d     = pend_v_q;
    pend_dp_d    = pend_dp_q;
    disp_v_d     = disp_v_q;
    disp_dp_d    = disp_dp_q;
    an_d         = AN_OFF;
    seg_d        = SEG_OFF;
    dp_d         = DP_OFF;
    frame_done_d = 1'b0;

    tick_c = en && (count_q == CNT_W'(REFRESH_DIV - 1));
    wrap_c = tick_c && (idx_q == IDX_W'(NDIGITS - 1));

    if (en) begin
      if (tick_c) begin
        count_d = '0;
        idx_d   = wrap_c ? '0 : idx_q + 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end

    // A load on the wrap cycle bypasses pending so the new frame shows it at once
    if (wrap_c) begin
      disp_v_d  = load ? value : pend_v_q;
      disp_dp_d = load ? dp_in : pend_dp_q;
    end
    if (load) begin
      pend_v_d  = value;
      pend_dp_d = dp_in;
    end

    upper_c = disp_v_d >> {idx_d, 2'b00};
    nib_c   = 4'(upper_c);
    blank_c = blank_lz && (idx_d != '0) && (upper_c == '0);

    if (en) begin
      an_d         = (NDIGITS'(1) << idx_d) ^ AN_OFF;
      seg_d        = (blank_c ? 7'h00 : glyph(nib_c)) ^ SEG_OFF;
      dp_d         = (blank_c ? 1'b0 : disp_dp_d[idx_d]) ^ DP_OFF;
      frame_done_d = wrap_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= '0;
      idx_q        <= '0;
      pend_v_q     <= '0;
      pend_dp_q    <= '0;
      disp_v_q     <= '0;
      disp_dp_q    <= '0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      frame_done_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      idx_q        <= idx_d;
      pend_v_q     <= pend_v_d;
      pend_dp_q    <= pend_dp_d;
      disp_v_q     <= disp_v_d;
      disp_dp_q    <= disp_dp_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver against a cycle-count based display model.
module tb_seg7_scan_driver;
  localparam int ND  = 4;
  localparam int DIV = 4;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          load;
  logic [15:0]   value;
  logic [3:0]    dp_in;
  logic          blank_lz;
  logic [6:0]    seg;
  logic          dp;
  logic [3:0]    an;
  logic          frame_done;

  int checks;
  int errors;

  // Model: scan position derived from the number of enabled cycles since reset
  int          act;
  logic [15:0] pend_v, disp_v;
  logic [3:0]  pend_dp, disp_dp;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp, exp_fd;
  logic [6:0]  glyph_tab [16];

  seg7_scan_driver #(
    .NDIGITS(ND), .REFRESH_DIV(DIV), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .value(value),
    .dp_in(dp_in), .blank_lz(blank_lz), .seg(seg), .dp(dp), .an(an),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_off();
    exp_an  = 4'hF;
    exp_seg = 7'h7F;
    exp_dp  = 1'b1;
    exp_fd  = 1'b0;
  endtask

  task automatic model_reset();
    act     = 0;
    pend_v  = '0;
    pend_dp = '0;
    disp_v  = '0;
    disp_dp = '0;
    set_off();
  endtask

  function automatic bit wrap_next();
    return (act % DIV == DIV - 1) && ((act / DIV) % ND == ND - 1);
  endfunction

  task automatic model_edge();
    bit          wrap;
    int          idx;
    logic [15:0] upper;
    if (!rst_n) begin
      model_reset();
      return;
    end
    wrap = en && wrap_next();
    if (en) act++;
    if (wrap) begin
      disp_v  = load ? value : pend_v;
      disp_dp = load ? dp_in : pend_dp;
    end
    if (load) begin
      pend_v  = value;
      pend_dp = dp_in;
    end
    if (!en) begin
      set_off();
      return;
    end
    idx    = (act / DIV) % ND;
    upper  = disp_v >> (4 * idx);
    exp_an = ~(4'b0001 << idx);
    exp_fd = wrap;
    if (blank_lz && idx > 0 && upper == 16'h0) begin
      exp_seg = 7'h7F;
      exp_dp  = 1'b1;
    end else begin
      exp_seg = ~glyph_tab[upper[3:0]];
      exp_dp  = ~disp_dp[idx];
    end
  endtask

  task automatic compare_all();
    check_eq("an", 32'(an), 32'(exp_an));
    check_eq("seg", 32'(seg), 32'(exp_seg));
    check_eq("dp", 32'(dp), 32'(exp_dp));
    check_eq("frame_done", 32'(frame_done), 32'(exp_fd));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  function automatic logic [15:0] rand_value();
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < ND; i++)
      if ($urandom_range(0, 1) == 1) v[4*i +: 4] = 4'($urandom_range(0, 15));
    return v;
  endfunction

  task automatic rand_inputs();
    en       = ($urandom_range(0, 9) != 0);
    load     = ($urandom_range(0, 3) == 0);
    value    = rand_value();
    dp_in    = 4'($urandom_range(0, 15));
    blank_lz = 1'($urandom_range(0, 1));
  endtask

  // Asserts reset between edges and checks outputs drop without a clock
  task automatic async_reset(input int hold);
    #3 rst_n = 1'b0;
    #1;
    check_eq("async_rst_an", 32'(an), 32'hF);
    check_eq("async_rst_seg", 32'(seg), 32'h7F);
    check_eq("async_rst_dp", 32'(dp), 32'h1);
    model_reset();
    load = 1'b0;
    for (int i = 0; i < hold; i++) cyc();
    #3 rst_n = 1'b1;
  endtask

  initial begin
    glyph_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    checks = 0;
    errors = 0;
    rst_n = 1'b1;
    en = 1'b0; load = 1'b0; value = '0; dp_in = '0; blank_lz = 1'b0;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    compare_all();
    for (int i = 0; i < 2; i++) cyc();
    #3 rst_n = 1'b1;

    // Free-running scan of zeros
    en = 1'b1;
    for (int i = 0; i < 40; i++) cyc();

    // Mid-frame load of 12AF, observed through the following frames
    value = 16'h12AF; dp_in = 4'b0100; load = 1'b1;
    cyc();
    load = 1'b0;
    for (int i = 0; i < 36; i++) cyc();

    // Leading-zero blanking
    blank_lz = 1'b1;
    value = 16'h0050; dp_in = 4'b0000; load = 1'b1;
    cyc();
    load = 1'b0;
    for (int i = 0; i < 36; i++) cyc();
    value = 16'h0000; load = 1'b1;
    cyc();
    load = 1'b0;
    for (int i = 0; i < 36; i++) cyc();
    blank_lz = 1'b0;

    // Load exactly on the wrap cycle (bypass), then one cycle after a wrap
    for (int i = 0; i < 64 && !wrap_next(); i++) cyc();
    value = 16'hBEEF; dp_in = 4'b1001; load = 1'b1;
    cyc();
    load = 1'b0;
    for (int i = 0; i < 20; i++) cyc();
    for (int i = 0; i < 64 && !wrap_next(); i++) cyc();
    cyc();
    value = 16'h3C4D; dp_in = 4'b0010; load = 1'b1;
    cyc();
    load = 1'b0;
    for (int i = 0; i < 34; i++) cyc();

    // Enable dropped mid-frame and restored
    for (int i = 0; i < 5; i++) cyc();
    en = 1'b0;
    for (int i = 0; i < 7; i++) cyc();
    en = 1'b1;
    for (int i = 0; i < 20; i++) cyc();

    // Asynchronous reset mid-frame
    value = 16'h9A7E; load = 1'b1;
    cyc();
    load = 1'b0;
    for (int i = 0; i < 25; i++) cyc();
    async_reset(3);
    for (int i = 0; i < 20; i++) cyc();

    // Randomized traffic with occasional mid-run resets
    for (int i = 0; i < 1500; i++) begin
      rand_inputs();
      cyc();
      if (i % 500 == 250) async_reset(2);
    end
    en = 1'b1; load = 1'b0;
    for (int i = 0; i < 20; i++) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
